// File: rtl/wishbone_pkg.sv
// Shared types and constants for the Wishbone slave RAM.
`timescale 1ns/1ps
package wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_slave_state_t;

  localparam int WB_BYTE = 8;

endpackage

// File: rtl/wb_ram_core.sv
// Word-organised RAM with per-byte write enables, synchronous write and
// combinational read.
`timescale 1ns/1ps
module wb_ram_core
  import wishbone_pkg::*;
#(
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8,
  parameter int depth        = 16,
  parameter int idx_width    = $clog2(depth)
) (
  input  logic                    clock,
  input  logic [strobe_width-1:0] we,
  input  logic [idx_width-1:0]    idx,
  input  logic [data_width-1:0]   wdata,
  output logic [data_width-1:0]   rdata
);

  logic [data_width-1:0] mem_q [depth];

  // Storage is deliberately not reset so contents survive a bus reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < strobe_width; i++) begin
      if (we[i]) begin
        mem_q[idx][i*WB_BYTE +: WB_BYTE] <= wdata[i*WB_BYTE +: WB_BYTE];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/wishbone_slave_ram.sv
// Wishbone classic single-cycle slave fronting a byte-writable RAM, with a
// configurable number of wait states before the registered acknowledge.
`timescale 1ns/1ps
module wishbone_slave_ram
  import wishbone_pkg::*;
#(
  parameter int addr_width   = 8,
  parameter int data_width   = 32,
  parameter int strobe_width = data_width / 8,
  parameter int depth        = 16,
  parameter int wait_states  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [addr_width-1:0]   wb_adr,
  input  logic [data_width-1:0]   wb_datwr,
  output logic [data_width-1:0]   wb_datrd,
  input  logic                    wb_we,
  input  logic                    wb_stb,
  output logic                    wb_ack,
  input  logic                    wb_cyc,
  input  logic [strobe_width-1:0] wb_sel
);

  localparam int IDX_W = $clog2(depth);
  localparam logic [3:0] WS_LOAD = 4'(wait_states - 1);

  wb_slave_state_t state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [IDX_W-1:0]        adr_q, adr_d;
  logic                    we_q, we_d;
  logic [data_width-1:0]   dat_q, dat_d;
  logic [strobe_width-1:0] sel_q, sel_d;
  logic [data_width-1:0]   datrd_q, datrd_d;
  logic                    ack_q, ack_d;

  logic                    commit_s;
  logic [IDX_W-1:0]        cmt_idx_s;
  logic                    cmt_we_s;
  logic [data_width-1:0]   cmt_dat_s;
  logic [strobe_width-1:0] cmt_sel_s;
  logic [strobe_width-1:0] ram_we_s;
  logic [data_width-1:0]   ram_rd_s;
  logic                    unused_adr_s;

  // Upper address bits are ignored so addresses alias modulo depth.
  assign unused_adr_s = ^wb_adr[addr_width-1:IDX_W];

  // Next-state, wait counter and request capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    adr_d    = adr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    sel_d    = sel_q;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_cyc && wb_stb) begin
          adr_d = wb_adr[IDX_W-1:0];
          we_d  = wb_we;
          dat_d = wb_datwr;
          sel_d = wb_sel;
          if (wait_states == 0) begin
            state_d  = ACK;
            commit_s = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = ACK;
          commit_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With zero wait states the commit happens on the capture edge, so the
  // live bus fields are used instead of the not-yet-loaded capture regs.
  always_comb begin
    if (state_q == IDLE) begin
      cmt_idx_s = wb_adr[IDX_W-1:0];
      cmt_we_s  = wb_we;
      cmt_dat_s = wb_datwr;
      cmt_sel_s = wb_sel;
    end else begin
      cmt_idx_s = adr_q;
      cmt_we_s  = we_q;
      cmt_dat_s = dat_q;
      cmt_sel_s = sel_q;
    end
    ram_we_s = (commit_s && cmt_we_s) ? cmt_sel_s : {strobe_width{1'b0}};
    datrd_d  = (commit_s && !cmt_we_s) ? ram_rd_s : datrd_q;
    ack_d    = (state_d == ACK);
  end

  // State, counter, capture and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= {IDX_W{1'b0}};
      we_q    <= 1'b0;
      dat_q   <= {data_width{1'b0}};
      sel_q   <= {strobe_width{1'b0}};
      datrd_q <= {data_width{1'b0}};
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      datrd_q <= datrd_d;
      ack_q   <= ack_d;
    end
  end

  wb_ram_core #(
    .data_width   (data_width),
    .strobe_width (strobe_width),
    .depth        (depth),
    .idx_width    (IDX_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we_s),
    .idx   (cmt_idx_s),
    .wdata (cmt_dat_s),
    .rdata (ram_rd_s)
  );

  assign wb_ack   = ack_q;
  assign wb_datrd = datrd_q;

endmodule

// File: tb/tb_wishbone_slave_ram.sv
// Directed bench: three slaves with 0, 2 and 3 wait states on one clock/reset.
`timescale 1ns/1ps
module tb_wishbone_slave_ram;

  logic        clock;
  logic        reset;
  logic [7:0]  adr_s   [3];
  logic [31:0] datwr_s [3];
  logic [31:0] datrd_s [3];
  logic        we_s    [3];
  logic        stb_s   [3];
  logic        ack_s   [3];
  logic        cyc_s   [3];
  logic [3:0]  sel_s   [3];

  int tests_run;
  int tests_failed;
  int lat;
  int acks;

  wishbone_slave_ram #(.wait_states(0)) u_dut0 (
    .clock(clock), .reset(reset), .wb_adr(adr_s[0]), .wb_datwr(datwr_s[0]),
    .wb_datrd(datrd_s[0]), .wb_we(we_s[0]), .wb_stb(stb_s[0]), .wb_ack(ack_s[0]),
    .wb_cyc(cyc_s[0]), .wb_sel(sel_s[0]));

  wishbone_slave_ram #(.wait_states(2)) u_dut2 (
    .clock(clock), .reset(reset), .wb_adr(adr_s[1]), .wb_datwr(datwr_s[1]),
    .wb_datrd(datrd_s[1]), .wb_we(we_s[1]), .wb_stb(stb_s[1]), .wb_ack(ack_s[1]),
    .wb_cyc(cyc_s[1]), .wb_sel(sel_s[1]));

  wishbone_slave_ram #(.wait_states(3)) u_dut3 (
    .clock(clock), .reset(reset), .wb_adr(adr_s[2]), .wb_datwr(datwr_s[2]),
    .wb_datrd(datrd_s[2]), .wb_we(we_s[2]), .wb_stb(stb_s[2]), .wb_ack(ack_s[2]),
    .wb_cyc(cyc_s[2]), .wb_sel(sel_s[2]));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one request on slave k and returns the number of edges until ack.
  // With mangle set, adr/dat are disturbed while the slave is waiting.
  task automatic xfer(input int k, input logic [7:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      input bit mangle, output int n);
    @(negedge clock);
    adr_s[k] = a; we_s[k] = w; datwr_s[k] = d; sel_s[k] = s;
    cyc_s[k] = 1'b1; stb_s[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (mangle) begin
        adr_s[k]   = adr_s[k] ^ 8'h01;
        datwr_s[k] = ~datwr_s[k];
      end
    end while (!ack_s[k] && n < 40);
    cyc_s[k] = 1'b0; stb_s[k] = 1'b0;
    @(negedge clock);
    check("ack_one_cycle", {31'd0, ack_s[k]}, 32'd0);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      adr_s[k] = 8'h00; datwr_s[k] = 32'h0; we_s[k] = 1'b0;
      stb_s[k] = 1'b0; cyc_s[k] = 1'b0; sel_s[k] = 4'h0;
    end
    repeat (2) @(negedge clock);
    check("rst_ack0", {31'd0, ack_s[0]}, 32'd0);
    check("rst_datrd0", datrd_s[0], 32'h0);
    check("rst_datrd2", datrd_s[2], 32'h0);
    reset = 1'b0;

    // Basic write then read with zero wait states.
    xfer(0, 8'h03, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, lat);
    check("ws0_wr_lat", lat, 32'd1);
    check("wr_no_datrd", datrd_s[0], 32'h0);
    xfer(0, 8'h03, 1'b0, 32'h0, 4'h0, 1'b0, lat);
    check("ws0_rd_lat", lat, 32'd1);
    check("rd_adr3", datrd_s[0], 32'hDEADBEEF);

    // Byte lanes, sel=0 write, datrd hold across writes.
    xfer(0, 8'h05, 1'b1, 32'h11223344, 4'hF, 1'b0, lat);
    xfer(0, 8'h05, 1'b1, 32'hAABBCCDD, 4'h5, 1'b0, lat);
    check("datrd_hold", datrd_s[0], 32'hDEADBEEF);
    xfer(0, 8'h05, 1'b1, 32'hFFFFFFFF, 4'h0, 1'b0, lat);
    check("sel0_acks", lat, 32'd1);
    xfer(0, 8'h05, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("byte_lanes", datrd_s[0], 32'h11BB33DD);
    xfer(0, 8'h06, 1'b1, 32'h55667788, 4'hA, 1'b0, lat);
    xfer(0, 8'h06, 1'b1, 32'h0000EEEE, 4'h1, 1'b0, lat);
    xfer(0, 8'h06, 1'b0, 32'h0, 4'h0, 1'b0, lat);
    check("lane_mask", datrd_s[0] & 32'hFF00FFFF, 32'h550077EE);

    // Address aliasing modulo depth.
    xfer(0, 8'h13, 1'b1, 32'h12345678, 4'hF, 1'b0, lat);
    xfer(0, 8'h03, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("alias", datrd_s[0], 32'h12345678);

    // Two wait states: latency, and bus changes during WAIT ignored.
    xfer(1, 8'h02, 1'b1, 32'h0BADCAFE, 4'hF, 1'b1, lat);
    check("ws2_wr_lat", lat, 32'd3);
    xfer(1, 8'h02, 1'b0, 32'h0, 4'hF, 1'b1, lat);
    check("ws2_rd_lat", lat, 32'd3);
    check("ws2_captured", datrd_s[1], 32'h0BADCAFE);
    xfer(1, 8'h03, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("ws2_no_mangle_wr", datrd_s[1] === 32'h0BADCAFE ? 32'd1 : 32'd0, 32'd0);

    // Three wait states: abort in first WAIT cycle leaves the word untouched.
    xfer(2, 8'h07, 1'b1, 32'h00000000, 4'hF, 1'b0, lat);
    check("ws3_lat", lat, 32'd4);
    @(negedge clock);
    adr_s[2] = 8'h07; we_s[2] = 1'b1; datwr_s[2] = 32'hFFFFFFFF; sel_s[2] = 4'hF;
    cyc_s[2] = 1'b1; stb_s[2] = 1'b1;
    @(negedge clock);
    cyc_s[2] = 1'b0; stb_s[2] = 1'b0;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ack_s[2]) acks++;
    end
    check("abort_no_ack", acks, 32'd0);
    xfer(2, 8'h07, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("abort_no_write", datrd_s[2], 32'h00000000);

    // Reset during WAIT of a write discards it; earlier data persists.
    xfer(1, 8'h01, 1'b1, 32'h01010101, 4'hF, 1'b0, lat);
    xfer(1, 8'h01, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("pre_reset_rd", datrd_s[1], 32'h01010101);
    @(negedge clock);
    adr_s[1] = 8'h01; we_s[1] = 1'b1; datwr_s[1] = 32'hCAFEF00D; sel_s[1] = 4'hF;
    cyc_s[1] = 1'b1; stb_s[1] = 1'b1;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ack", {31'd0, ack_s[1]}, 32'd0);
    check("async_rst_datrd", datrd_s[1], 32'h0);
    check("async_rst_datrd0", datrd_s[0], 32'h0);
    @(negedge clock);
    cyc_s[1] = 1'b0; stb_s[1] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    xfer(1, 8'h01, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("rst_discard_wr", datrd_s[1], 32'h01010101);
    xfer(0, 8'h05, 1'b0, 32'h0, 4'hF, 1'b0, lat);
    check("ram_survives_rst", datrd_s[0], 32'h11BB33DD);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
